acc_core: RTL and testbench
===========================

# acc_core

Parametrised accumulator processor core: the next generation of the team's 8-bit accumulator core, with independent data/address widths, a unified memory bus with a stallable req/ack handshake, store-to-memory, immediate operands, carry-chained arithmetic, N/Z/C/V flags with negatable conditional jumps, and a halt state. It sits between the instruction/data RAM and the debug/test harness. One multi-cycle FSM issues at most one memory transaction at a time.

## Interface
- DATA_W, 8, accumulator/memory word width; minimum 8
- ADDR_W, 8, memory address width; must satisfy ADDR_W <= DATA_W
- clk  in  1  clock; all state changes on the rising edge
- reset_n  in  1  synchronous, active-low reset
- mem_req  out  1  transaction request; held until accepted
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  transaction address
- mem_wdata  out  DATA_W  store data; equals A while mem_we
- mem_rdata  in  DATA_W  read data; sampled in the accept cycle
- mem_ack  in  1  the transaction completes in any cycle where mem_req && mem_ack; may be combinational
- pc  out  ADDR_W  current program counter
- acc  out  DATA_W  accumulator A
- flags  out  4  {N, V, C, Z}
- halted  out  1  core stopped
- fault  out  1  halted on an illegal opcode

## Operation
- Instruction word: class = word[DATA_W-1:DATA_W-3], sub = word[2:0]. Every class except 0 and 7 is followed by one argument word at pc+1.
- Class 0 SYS: sub[0]=0 is NOP; sub[0]=1 is HALT.
- Class 1 LDI: A <= arg.
- Class 2 LD: A <= MEM[arg[ADDR_W-1:0]].
- Class 3 ST: MEM[arg] <= A.
- Class 4 ALU-mem: A <= A op MEM[arg].
- Class 5 ALU-imm: A <= A op arg.
- Class 6 JMP: sub[1:0] selects the condition: 0 always, 1 Z, 2 C, 3 V. sub[2] negates it. If taken, pc <= arg[ADDR_W-1:0]; otherwise pc += 2.
- Class 7: illegal. Sets halted and fault.
- ALU ops by sub: 0 ADD, 1 ADC (+C), 2 SUB, 3 SBB (−C), 4 AND, 5 OR, 6 XOR, 7 SHR (the operand is ignored; C <= A[0]).
- Flags update only on ALU classes. Z = result is zero. N = result MSB.
- Arithmetic uses a DATA_W+1-bit sum. For SUB/SBB, C is the borrow. V is two's-complement overflow. Logic ops clear C and V.
- LD/LDI do not touch flags.
- FSM states:
  - FETCH: read MEM[pc].
  - ARG: read MEM[pc+1].
  - DATA: read or write MEM[arg].
  - HALT.
- FETCH goes to ARG on ack, except class 0 and class 7. NOP does pc += 1 and returns to FETCH. HALT and class 7 go to HALT.
- ARG executes LDI/ALU-imm/JMP on ack and returns to FETCH. For LD/ST/ALU-mem it latches arg and moves to DATA.
- DATA executes on ack, does pc += 2 and returns to FETCH.
- HALT: mem_req = 0 and the core stays there until reset. pc keeps pointing at the HALT or illegal word.
- pc arithmetic wraps modulo 2^ADDR_W. pc+1 also wraps for the argument fetch.

## Timing
- Reset (reset_n low at an edge) forces:
  - state = FETCH; pc = 0; A = 0; flags = 0
  - halted = 0; fault = 0
  - mem_req = 0 during the reset cycle; mem_we = 0
- Reset overrides any state, including a mid-transaction state. An outstanding request is dropped with no write side effect.
- mem_req is asserted from the first cycle after reset release.
- mem_req, mem_we, mem_addr and mem_wdata are registered or state-decoded. They stay stable while mem_req && !mem_ack.
- A new request may start in the cycle immediately after an accept, so there are no bubbles.
- Latency in transactions, with zero-wait ack giving 1 cycle each:
  - NOP: 1
  - HALT: 1
  - LDI, ALU-imm, JMP: 2
  - LD, ST, ALU-mem: 3
- Each wait cycle (req && !ack) adds 1 cycle.
- A, flags and pc are visible on the outputs the cycle after the accepting edge.
- halted and fault rise the cycle after the HALT/illegal word is accepted.

## Structure
- Package acc_core_pkg holds:
  - class enum (SYS..ILL) and ALU op enum
  - jump condition codes
  - flag index constants N/V/C/Z
  - FSM state enum
- Sub-module acc_core_alu is combinational and parametrised on DATA_W. Inputs: a, b, op, cin. Outputs: result and {N, V, C, Z}.

## Test plan
- Reset release with zero-wait memory: program LDI 0x05; ALU-imm ADD 0xFB -> A = 0x00, Z = 1, C = 1, V = 0, pc = 4 after 4 cycles.
- Signed overflow: LDI 0x7F; ADD imm 0x01 -> A = 0x80, N = 1, V = 1, C = 0. Then SBB imm 0x00 -> A = 0x80, C = 0.
- Stall: mem_ack held low for 3 cycles during the ST data phase -> mem_addr/mem_wdata/mem_we stay stable. Exactly one write lands. Total instruction time is 6 cycles.
- Conditional jump: with Z = 1, JMP Z 0x10 -> pc = 0x10. Negated (sub = 5) -> pc += 2. Target 0xFF at ADDR_W = 8, followed by a two-word instruction -> the argument fetch wraps to address 0x00.
- Illegal opcode 0xE0 -> halted = 1, fault = 1, mem_req = 0 thereafter, pc unchanged. HALT word 0x01 -> halted = 1, fault = 0.
- Reset asserted mid-DATA of an ST with ack withheld -> no write is observed, and all outputs return to their reset values next cycle. Repeat with DATA_W = 16, ADDR_W = 10 for an ADC chain across two words.

Source files
------------

// File: rtl/acc_core_pkg.sv
// Shared types and constants for the acc_core accumulator processor.
// Instruction classes, ALU ops, jump conditions, flag positions and FSM states.
package acc_core_pkg;

    typedef enum logic [2:0] {
        CLS_SYS  = 3'd0,
        CLS_LDI  = 3'd1,
        CLS_LD   = 3'd2,
        CLS_ST   = 3'd3,
        CLS_ALUM = 3'd4,
        CLS_ALUI = 3'd5,
        CLS_JMP  = 3'd6,
        CLS_ILL  = 3'd7
    } cls_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_ADC = 3'd1,
        OP_SUB = 3'd2,
        OP_SBB = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_SHR = 3'd7
    } alu_op_e;

    localparam logic [1:0] JC_ALWAYS = 2'd0;
    localparam logic [1:0] JC_Z      = 2'd1;
    localparam logic [1:0] JC_C      = 2'd2;
    localparam logic [1:0] JC_V      = 2'd3;

    // Bit positions inside the {N, V, C, Z} flag vector.
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_ARG   = 2'd1,
        ST_DATA  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/acc_core_alu.sv
// Combinational ALU for acc_core: add/sub with carry-in, logic ops and shift-right.
// Flags come out as {N, V, C, Z}; C is the borrow for SUB/SBB.
module acc_core_alu
    import acc_core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    input  logic              cin,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    localparam int W1 = DATA_W + 1;

    logic [DATA_W:0] wide;
    logic            c_out;
    logic            v_out;
    logic            cin_eff;

    // ADC and SBB are the odd opcodes; plain ADD/SUB ignore the incoming carry.
    assign cin_eff = cin & op[0];

    always_comb begin
        wide   = '0;
        c_out  = 1'b0;
        v_out  = 1'b0;
        result = '0;
        case (op)
            OP_ADD, OP_ADC: begin
                wide   = {1'b0, a} + {1'b0, b} + W1'(cin_eff);
                result = wide[DATA_W-1:0];
                c_out  = wide[DATA_W];
                v_out  = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB, OP_SBB: begin
                wide   = {1'b0, a} - {1'b0, b} - W1'(cin_eff);
                result = wide[DATA_W-1:0];
                c_out  = wide[DATA_W];
                v_out  = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHR: begin
                result = a >> 1;
                c_out  = a[0];
            end
            default: result = '0;
        endcase
    end

    assign flags = {result[DATA_W-1], v_out, c_out, ~|result};

endmodule

// File: rtl/acc_core.sv
// Multi-cycle accumulator core on a single req/ack memory bus, one transaction at a time.
//   state    | meaning
//   FETCH    | read instruction word at pc
//   ARG      | read argument word at pc+1; execute LDI/ALU-imm/JMP
//   DATA     | read or write MEM[arg]; execute LD/ST/ALU-mem
//   HALT     | stopped until reset, no bus requests
module acc_core
    import acc_core_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic [3:0]        flags,
    output logic              halted,
    output logic              fault
);

    state_e            state;
    logic              run;
    cls_e              ir_cls;
    logic [2:0]        ir_sub;
    logic [ADDR_W-1:0] arg_addr;
    logic [ADDR_W-1:0] pc_plus2;
    cls_e              fetch_cls;
    logic              xfer;
    logic              cond;
    logic              take_jump;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;

    // Gating with reset_n keeps the bus quiet during the reset cycle itself, so an
    // in-flight store can never land while reset is being applied.
    assign mem_req   = run && reset_n && (state != ST_HALT);
    assign mem_we    = mem_req && (state == ST_DATA) && (ir_cls == CLS_ST);
    assign mem_wdata = acc;
    assign xfer      = mem_req && mem_ack;
    assign fetch_cls = cls_e'(mem_rdata[DATA_W-1 -: 3]);
    assign pc_plus2  = pc + ADDR_W'(2);

    always_comb begin
        mem_addr = pc;
        case (state)
            ST_ARG:  mem_addr = pc + ADDR_W'(1);
            ST_DATA: mem_addr = arg_addr;
            default: mem_addr = pc;
        endcase
    end

    always_comb begin
        cond = 1'b1;
        case (ir_sub[1:0])
            JC_Z:    cond = flags[FLAG_Z];
            JC_C:    cond = flags[FLAG_C];
            JC_V:    cond = flags[FLAG_V];
            default: cond = 1'b1;
        endcase
        take_jump = cond ^ ir_sub[2];
    end

    // Operand b is always the word on the bus: the immediate in ARG, MEM[arg] in DATA.
    acc_core_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (acc),
        .b      (mem_rdata),
        .op     (ir_sub),
        .cin    (flags[FLAG_C]),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_FETCH;
            run      <= 1'b0;
            pc       <= '0;
            acc      <= '0;
            flags    <= '0;
            halted   <= 1'b0;
            fault    <= 1'b0;
            ir_cls   <= CLS_SYS;
            ir_sub   <= '0;
            arg_addr <= '0;
        end else begin
            run <= 1'b1;
            if (xfer) begin
                case (state)
                    ST_FETCH: begin
                        ir_cls <= fetch_cls;
                        ir_sub <= mem_rdata[2:0];
                        case (fetch_cls)
                            CLS_SYS: begin
                                if (mem_rdata[0]) begin
                                    state  <= ST_HALT;
                                    halted <= 1'b1;
                                end else begin
                                    pc <= pc + ADDR_W'(1);
                                end
                            end
                            CLS_ILL: begin
                                state  <= ST_HALT;
                                halted <= 1'b1;
                                fault  <= 1'b1;
                            end
                            default: state <= ST_ARG;
                        endcase
                    end
                    ST_ARG: begin
                        case (ir_cls)
                            CLS_LDI: begin
                                acc   <= mem_rdata;
                                pc    <= pc_plus2;
                                state <= ST_FETCH;
                            end
                            CLS_ALUI: begin
                                acc   <= alu_result;
                                flags <= alu_flags;
                                pc    <= pc_plus2;
                                state <= ST_FETCH;
                            end
                            CLS_JMP: begin
                                pc    <= take_jump ? mem_rdata[ADDR_W-1:0] : pc_plus2;
                                state <= ST_FETCH;
                            end
                            default: begin
                                arg_addr <= mem_rdata[ADDR_W-1:0];
                                state    <= ST_DATA;
                            end
                        endcase
                    end
                    ST_DATA: begin
                        case (ir_cls)
                            CLS_LD:   acc <= mem_rdata;
                            CLS_ALUM: begin
                                acc   <= alu_result;
                                flags <= alu_flags;
                            end
                            default: ;
                        endcase
                        pc    <= pc_plus2;
                        state <= ST_FETCH;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acc_core.sv
// Self-checking bench for acc_core: 8-bit core for programs/flags/stalls/jumps,
// plus a DATA_W=16/ADDR_W=10 core for the carry chain and mid-store reset.
module tb_acc_core;

    typedef struct {
        logic [7:0] acc;
        logic [3:0] flags;
        logic [7:0] pc;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8_n = 1'b0;
    logic        ack8   = 1'b1;
    logic        req8, we8, halted8, fault8;
    logic [7:0]  addr8, wdata8, rdata8, pc8, acc8;
    logic [3:0]  flags8;
    logic [7:0]  mem8 [0:255];

    logic        rst16_n = 1'b0;
    logic        ack16   = 1'b1;
    logic        req16, we16, halted16, fault16;
    logic [9:0]  addr16, pc16;
    logic [15:0] wdata16, rdata16, acc16;
    logic [3:0]  flags16;
    logic [15:0] mem16 [0:1023];

    assign rdata8  = mem8[addr8];
    assign rdata16 = mem16[addr16];

    acc_core #(.DATA_W(8), .ADDR_W(8)) dut8 (
        .clk(clk), .reset_n(rst8_n), .mem_req(req8), .mem_we(we8), .mem_addr(addr8),
        .mem_wdata(wdata8), .mem_rdata(rdata8), .mem_ack(ack8), .pc(pc8), .acc(acc8),
        .flags(flags8), .halted(halted8), .fault(fault8)
    );

    acc_core #(.DATA_W(16), .ADDR_W(10)) dut16 (
        .clk(clk), .reset_n(rst16_n), .mem_req(req16), .mem_we(we16), .mem_addr(addr16),
        .mem_wdata(wdata16), .mem_rdata(rdata16), .mem_ack(ack16), .pc(pc16), .acc(acc16),
        .flags(flags16), .halted(halted16), .fault(fault16)
    );

    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    logic [15:0] wr_q[$];

    function automatic void expect_step(logic [7:0] a, logic [3:0] f, logic [7:0] p, int c);
        exp_t e;
        e.acc = a; e.flags = f; e.pc = p; e.cyc = c;
        exp_q.push_back(e);
    endfunction

    task automatic reset8();
        rst8_n = 1'b0;
        ack8   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 256; i++) mem8[i] = 8'h01;
        exp_q.delete();
        wr_q.delete();
    endtask

    task automatic release8();
        rst8_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs the 8-bit core until halted; the first 'stall' write-request cycles get no ack.
    task automatic run8(input int budget, input int stall, output int rc);
        int         left = stall;
        int         k = 0;
        bit         hold = 0;
        logic [7:0] h_addr = 8'h00, h_data = 8'h00;
        logic       h_we = 1'b0;
        logic [7:0] prev_pc = pc8;
        exp_t       e;
        rc = 0;
        while (k < budget && !halted8) begin
            if (hold) begin
                checks++;
                if (req8 !== 1'b1 || we8 !== h_we || addr8 !== h_addr || wdata8 !== h_data) begin
                    errors++;
                    $display("FAIL stall_hold: req=%b we=%b addr=%h wdata=%h, want req=1 we=%b addr=%h wdata=%h",
                             req8, we8, addr8, wdata8, h_we, h_addr, h_data);
                end
            end
            if (left > 0 && req8 && we8) begin
                ack8 = 1'b0;
                left--;
            end else begin
                ack8 = 1'b1;
            end
            hold   = req8 && !ack8;
            h_addr = addr8;
            h_data = wdata8;
            h_we   = we8;
            if (req8) rc++;
            if (req8 && ack8 && we8) wr_q.push_back({addr8, wdata8});
            @(negedge clk);
            k++;
            if (pc8 !== prev_pc) begin
                prev_pc = pc8;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: pc=%h acc=%h flags=%b at cycle %0d, want no step", pc8, acc8, flags8, k);
                end else begin
                    e = exp_q.pop_front();
                    if (acc8 !== e.acc || flags8 !== e.flags || pc8 !== e.pc || k != e.cyc) begin
                        errors++;
                        $display("FAIL sb_step: acc=%h flags=%b pc=%h cyc=%0d, want acc=%h flags=%b pc=%h cyc=%0d",
                                 acc8, flags8, pc8, k, e.acc, e.flags, e.pc, e.cyc);
                    end
                end
            end
        end
        ack8 = 1'b1;
        checks++;
        if (!halted8) begin
            errors++;
            $display("FAIL run_timeout: halted=%b after %0d cycles, want 1", halted8, k);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_missing: %0d steps left, want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset8();
        checks++;
        if ({pc8, acc8, flags8, halted8, fault8, req8, we8} !== 25'd0) begin
            errors++;
            $display("FAIL reset8: pc=%h acc=%h flags=%b halted=%b fault=%b req=%b we=%b, want all 0",
                     pc8, acc8, flags8, halted8, fault8, req8, we8);
        end
        checks++;
        if ({pc16, acc16, flags16, halted16, fault16, req16, we16} !== 34'd0) begin
            errors++;
            $display("FAIL reset16: pc=%h acc=%h flags=%b halted=%b fault=%b req=%b we=%b, want all 0",
                     pc16, acc16, flags16, halted16, fault16, req16, we16);
        end
        release8();
        checks++;
        if (req8 !== 1'b1 || we8 !== 1'b0 || addr8 !== 8'h00) begin
            errors++;
            $display("FAIL first_req: req=%b we=%b addr=%h, want req=1 we=0 addr=00", req8, we8, addr8);
        end
    endtask

    task automatic test_basic();
        int rc;
        reset8();
        mem8[0] = 8'h20; mem8[1] = 8'h05; mem8[2] = 8'hA0; mem8[3] = 8'hFB; mem8[4] = 8'h01;
        expect_step(8'h05, 4'b0000, 8'h02, 2);
        expect_step(8'h00, 4'b0011, 8'h04, 4);
        release8();
        run8(40, 0, rc);
        checks++;
        if (rc != 5 || halted8 !== 1'b1 || fault8 !== 1'b0 || pc8 !== 8'h04 || req8 !== 1'b0) begin
            errors++;
            $display("FAIL basic_halt: cycles=%0d halted=%b fault=%b pc=%h req=%b, want 5 1 0 04 0",
                     rc, halted8, fault8, pc8, req8);
        end
    endtask

    task automatic test_overflow();
        int rc;
        reset8();
        mem8[0] = 8'h20; mem8[1] = 8'h7F; mem8[2] = 8'hA0; mem8[3] = 8'h01;
        mem8[4] = 8'hA3; mem8[5] = 8'h00; mem8[6] = 8'h01;
        expect_step(8'h7F, 4'b0000, 8'h02, 2);
        expect_step(8'h80, 4'b1100, 8'h04, 4);
        expect_step(8'h80, 4'b1000, 8'h06, 6);
        release8();
        run8(40, 0, rc);
        checks++;
        if (rc != 7) begin
            errors++;
            $display("FAIL overflow_cycles: %0d, want 7", rc);
        end
    endtask

    task automatic test_alu_mem();
        int rc;
        reset8();
        mem8[0]  = 8'h20; mem8[1]  = 8'h0F;
        mem8[2]  = 8'h85; mem8[3]  = 8'h40;
        mem8[4]  = 8'hA6; mem8[5]  = 8'hFF;
        mem8[6]  = 8'h40; mem8[7]  = 8'h41;
        mem8[8]  = 8'hA7; mem8[9]  = 8'h00;
        mem8[10] = 8'hA2; mem8[11] = 8'h02;
        mem8[12] = 8'h01;
        mem8[8'h40] = 8'hF0; mem8[8'h41] = 8'h03;
        expect_step(8'h0F, 4'b0000, 8'h02, 2);
        expect_step(8'hFF, 4'b1000, 8'h04, 5);
        expect_step(8'h00, 4'b0001, 8'h06, 7);
        expect_step(8'h03, 4'b0001, 8'h08, 10);
        expect_step(8'h01, 4'b0010, 8'h0A, 12);
        expect_step(8'hFF, 4'b1010, 8'h0C, 14);
        release8();
        run8(60, 0, rc);
        checks++;
        if (rc != 15) begin
            errors++;
            $display("FAIL alu_mem_cycles: %0d, want 15", rc);
        end
    endtask

    task automatic test_stall();
        int rc;
        reset8();
        mem8[0] = 8'h20; mem8[1] = 8'h5A; mem8[2] = 8'h60; mem8[3] = 8'h80; mem8[4] = 8'h01;
        expect_step(8'h5A, 4'b0000, 8'h02, 2);
        expect_step(8'h5A, 4'b0000, 8'h04, 8);
        release8();
        run8(60, 3, rc);
        checks++;
        if (rc != 9) begin
            errors++;
            $display("FAIL stall_cycles: %0d, want 9", rc);
        end
        checks++;
        if (wr_q.size() != 1 || wr_q[0] !== 16'h805A) begin
            errors++;
            $display("FAIL stall_writes: count=%0d first=%h, want count=1 first=805A",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 16'h0000);
        end
    endtask

    task automatic test_jump();
        int rc;
        reset8();
        mem8[0] = 8'hA4; mem8[1] = 8'h01;
        mem8[2] = 8'hC1; mem8[3] = 8'h10;
        mem8[8'h10] = 8'hC5; mem8[8'h11] = 8'h20;
        mem8[8'h12] = 8'hC2; mem8[8'h13] = 8'h30;
        mem8[8'h14] = 8'hC6; mem8[8'h15] = 8'hFF;
        mem8[8'hFF] = 8'h20;
        expect_step(8'h00, 4'b0001, 8'h02, 2);
        expect_step(8'h00, 4'b0001, 8'h10, 4);
        expect_step(8'h00, 4'b0001, 8'h12, 6);
        expect_step(8'h00, 4'b0001, 8'h14, 8);
        expect_step(8'h00, 4'b0001, 8'hFF, 10);
        expect_step(8'hA4, 4'b0001, 8'h01, 12);
        release8();
        run8(60, 0, rc);
        checks++;
        if (rc != 13 || pc8 !== 8'h01 || fault8 !== 1'b0) begin
            errors++;
            $display("FAIL jump_end: cycles=%0d pc=%h fault=%b, want 13 01 0", rc, pc8, fault8);
        end
    endtask

    task automatic test_illegal();
        int rc;
        bit any_req = 0;
        reset8();
        mem8[0] = 8'h20; mem8[1] = 8'h33; mem8[2] = 8'hE0;
        expect_step(8'h33, 4'b0000, 8'h02, 2);
        release8();
        run8(40, 0, rc);
        checks++;
        if (rc != 3 || halted8 !== 1'b1 || fault8 !== 1'b1 || pc8 !== 8'h02) begin
            errors++;
            $display("FAIL illegal_halt: cycles=%0d halted=%b fault=%b pc=%h, want 3 1 1 02",
                     rc, halted8, fault8, pc8);
        end
        for (int i = 0; i < 4; i++) begin
            if (req8 !== 1'b0 || pc8 !== 8'h02) any_req = 1;
            @(negedge clk);
        end
        checks++;
        if (any_req) begin
            errors++;
            $display("FAIL illegal_quiet: req or pc moved after halt (req=%b pc=%h), want req=0 pc=02", req8, pc8);
        end
    endtask

    task automatic test_reset_mid8();
        int k = 0;
        reset8();
        mem8[0] = 8'h20; mem8[1] = 8'h77; mem8[2] = 8'h60; mem8[3] = 8'h90;
        release8();
        while (k < 20 && !(req8 && we8)) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!(req8 && we8) || addr8 !== 8'h90 || wdata8 !== 8'h77) begin
            errors++;
            $display("FAIL mid8_store: req=%b we=%b addr=%h wdata=%h, want 1 1 90 77", req8, we8, addr8, wdata8);
        end
        ack8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst8_n = 1'b0;
        ack8   = 1'b1;
        #1;
        checks++;
        if (req8 && we8 && ack8) begin
            errors++;
            $display("FAIL mid8_write: store accepted under reset (req=%b we=%b), want req=0", req8, we8);
        end
        @(negedge clk);
        checks++;
        if ({pc8, acc8, flags8, halted8, fault8, req8, we8} !== 25'd0) begin
            errors++;
            $display("FAIL mid8_reset: pc=%h acc=%h flags=%b halted=%b fault=%b req=%b we=%b, want all 0",
                     pc8, acc8, flags8, halted8, fault8, req8, we8);
        end
    endtask

    task automatic test_reset_mid16();
        int k = 0;
        for (int i = 0; i < 1024; i++) mem16[i] = 16'h0001;
        mem16[0] = 16'h2000; mem16[1] = 16'hFFFF;
        mem16[2] = 16'hA000; mem16[3] = 16'h0001;
        mem16[4] = 16'hA001; mem16[5] = 16'h0000;
        mem16[6] = 16'h6000; mem16[7] = 16'h0200;
        ack16   = 1'b1;
        rst16_n = 1'b1;
        @(negedge clk);
        while (k < 30 && !(req16 && we16)) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!(req16 && we16) || k != 8 || acc16 !== 16'h0001 || flags16 !== 4'b0000 ||
            addr16 !== 10'h200 || wdata16 !== 16'h0001) begin
            errors++;
            $display("FAIL adc16: store at cycle %0d acc=%h flags=%b addr=%h wdata=%h, want 8 0001 0000 200 0001",
                     k, acc16, flags16, addr16, wdata16);
        end
        ack16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst16_n = 1'b0;
        ack16   = 1'b1;
        #1;
        checks++;
        if (req16 && we16 && ack16) begin
            errors++;
            $display("FAIL mid16_write: store accepted under reset (req=%b we=%b), want req=0", req16, we16);
        end
        @(negedge clk);
        checks++;
        if ({pc16, acc16, flags16, halted16, fault16, req16, we16} !== 34'd0) begin
            errors++;
            $display("FAIL mid16_reset: pc=%h acc=%h flags=%b halted=%b fault=%b req=%b we=%b, want all 0",
                     pc16, acc16, flags16, halted16, fault16, req16, we16);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_alu_mem();
        test_stall();
        test_jump();
        test_illegal();
        test_reset_mid8();
        test_reset_mid16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
